alu_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one combinational `alu` instance between two requesters, e.g. the main execute path and an address/auxiliary unit.
- Each port issues operations over a valid/ready request channel and receives results over a valid/ready response channel.
- The block registers the granted operation, drives the external ALU from that register, and captures the result into a per-port response slot.
- It sits between the requesters and the `alu` module; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one external combinational ALU.
// Each port has at most one op in flight; results return through a per-port response slot.
module alu_arbiter #(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [15:0]       op_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid must not wait on ready, and ready never looks at the same port's valid.

  logic              iss_vld;
  logic              iss_port;
  logic [CTRL_W-1:0] iss_ctrl;
  logic [DATA_W-1:0] iss_src1;
  logic [DATA_W-1:0] iss_src2;
  logic              rr;
  logic              elig0, elig1;
  logic              grant0, grant1;

  // A port is eligible when nothing of its own is in the ALU and its response slot frees up this cycle.
  always_comb begin
    elig0      = !(iss_vld && !iss_port) && (!resp0_valid || resp0_ready);
    elig1      = !(iss_vld &&  iss_port) && (!resp1_valid || resp1_ready);
    req0_ready = !rst && elig0 && (!rr || !(req1_valid && elig1));
    req1_ready = !rst && elig1 && ( rr || !(req0_valid && elig0));
    grant0     = req0_valid && req0_ready;
    grant1     = req1_valid && req1_ready;
  end

  assign alu_control = iss_vld ? iss_ctrl : '0;
  assign alu_src1    = iss_vld ? iss_src1 : '0;
  assign alu_src2    = iss_vld ? iss_src2 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_vld      <= 1'b0;
      iss_port     <= 1'b0;
      iss_ctrl     <= '0;
      iss_src1     <= '0;
      iss_src2     <= '0;
      rr           <= 1'b0;
      op_count     <= 16'd0;
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
    end else begin
      if (grant0) begin
        iss_vld  <= 1'b1;
        iss_port <= 1'b0;
        iss_ctrl <= req0_ctrl;
        iss_src1 <= req0_src1;
        iss_src2 <= req0_src2;
        rr       <= 1'b1;
        op_count <= op_count + 16'd1;
      end else if (grant1) begin
        iss_vld  <= 1'b1;
        iss_port <= 1'b1;
        iss_ctrl <= req1_ctrl;
        iss_src1 <= req1_src1;
        iss_src2 <= req1_src2;
        rr       <= 1'b0;
        op_count <= op_count + 16'd1;
      end else begin
        iss_vld <= 1'b0;
      end

      // Completion takes priority over drain; eligibility keeps them from colliding.
      if (iss_vld && !iss_port) begin
        resp0_valid  <= 1'b1;
        resp0_result <= alu_result;
      end else if (resp0_valid && resp0_ready) begin
        resp0_valid <= 1'b0;
      end

      if (iss_vld && iss_port) begin
        resp1_valid  <= 1'b1;
        resp1_result <= alu_result;
      end else if (resp1_valid && resp1_ready) begin
        resp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, per-port request/response model, directed and random traffic.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic [12:0] req_ctrl   [2];
  logic [31:0] req_src1   [2];
  logic [31:0] req_src2   [2];
  logic        resp_ready [2];

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_result, resp1_result;
  logic [12:0] alu_control;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req0_ready), .req0_ctrl(req_ctrl[0]),
    .req0_src1(req_src1[0]), .req0_src2(req_src2[0]),
    .resp0_valid(resp0_valid), .resp0_ready(resp_ready[0]), .resp0_result(resp0_result),
    .req1_valid(req_valid[1]), .req1_ready(req1_ready), .req1_ctrl(req_ctrl[1]),
    .req1_src1(req_src1[1]), .req1_src2(req_src2[1]),
    .resp1_valid(resp1_valid), .resp1_ready(resp_ready[1]), .resp1_result(resp1_result),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .op_count(op_count)
  );

  // Priority-select ALU: highest control bit wins; shifts move src2 by src1[4:0].
  function automatic logic [31:0] alu_model(logic [12:0] c, logic [31:0] a, logic [31:0] b);
    if (c[12]) return ~(a & b);
    if (c[11]) return a + b;
    if (c[10]) return a - b;
    if (c[9])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (c[8])  return (a < b) ? 32'd1 : 32'd0;
    if (c[7])  return a & b;
    if (c[6])  return ~(a | b);
    if (c[5])  return a | b;
    if (c[4])  return a ^ b;
    if (c[3])  return b << a[4:0];
    if (c[2])  return b >> a[4:0];
    if (c[1])  return $unsigned($signed(b) >>> a[4:0]);
    if (c[0])  return {b[15:0], 16'h0000};
    return 32'd0;
  endfunction

  assign alu_result = alu_model(alu_control, alu_src1, alu_src2);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: per-port phase (0 idle, 1 op in ALU, 2 result waiting) plus expected-result queues.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          m_stage [2];
  int          m_rr;
  logic [15:0] m_count;
  logic        m_alu_vld;
  logic [12:0] m_alu_ctrl;
  logic [31:0] m_alu_src1, m_alu_src2;
  logic        el [2];
  logic        rd [2];
  int          grant_cyc [2];
  int          resp_cyc  [2];
  int          n_resp    [2];
  logic [31:0] last_res  [2];
  int          m_grants;

  function automatic logic dut_req_ready(int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction
  function automatic logic dut_resp_valid(int p);
    return (p == 0) ? resp0_valid : resp1_valid;
  endfunction
  function automatic logic [31:0] dut_resp_result(int p);
    return (p == 0) ? resp0_result : resp1_result;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      m_stage[0] = 0; m_stage[1] = 0;
      m_rr = 0; m_count = 16'd0; m_alu_vld = 1'b0;
      chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("reset_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
      chk("reset_op_count", {16'd0, op_count}, 32'd0);
      chk("reset_alu_control", {19'd0, alu_control}, 32'd0);
    end else begin
      for (int p = 0; p < 2; p++)
        el[p] = (m_stage[p] != 1) && (m_stage[p] != 2 || resp_ready[p]);
      for (int p = 0; p < 2; p++)
        rd[p] = el[p] && (m_rr == p || !(req_valid[1-p] && el[1-p]));
      for (int p = 0; p < 2; p++) begin
        chk(p == 0 ? "req0_ready" : "req1_ready", {31'd0, dut_req_ready(p)}, {31'd0, rd[p]});
        chk(p == 0 ? "resp0_valid" : "resp1_valid", {31'd0, dut_resp_valid(p)},
            {31'd0, m_stage[p] == 2});
        if (m_stage[p] == 2)
          chk(p == 0 ? "resp0_result" : "resp1_result", dut_resp_result(p),
              p == 0 ? exp_q0[0] : exp_q1[0]);
      end
      chk("alu_control", {19'd0, alu_control}, {19'd0, m_alu_vld ? m_alu_ctrl : 13'd0});
      chk("alu_src1", alu_src1, m_alu_vld ? m_alu_src1 : 32'd0);
      chk("alu_src2", alu_src2, m_alu_vld ? m_alu_src2 : 32'd0);
      chk("op_count", {16'd0, op_count}, {16'd0, m_count});

      // Advance to the state after the coming rising edge.
      m_alu_vld = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (m_stage[p] == 2 && resp_ready[p]) begin
          last_res[p] = dut_resp_result(p);
          resp_cyc[p] = cyc;
          n_resp[p]++;
          if (p == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
          m_stage[p] = 0;
        end else if (m_stage[p] == 1) begin
          m_stage[p] = 2;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && rd[p]) begin
          if (p == 0) exp_q0.push_back(alu_model(req_ctrl[0], req_src1[0], req_src2[0]));
          else        exp_q1.push_back(alu_model(req_ctrl[1], req_src1[1], req_src2[1]));
          m_stage[p] = 1;
          m_alu_vld = 1'b1;
          m_alu_ctrl = req_ctrl[p];
          m_alu_src1 = req_src1[p];
          m_alu_src2 = req_src2[p];
          m_rr = 1 - p;
          m_count = m_count + 16'd1;
          m_grants++;
          grant_cyc[p] = cyc;
        end
      end
    end
  end

  // Callers start at posedge+1; returns at posedge+1 just after the granting edge.
  task automatic send(input int p, input logic [12:0] c, input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    req_ctrl[p] = c; req_src1[p] = a; req_src2[p] = b; req_valid[p] = 1'b1;
    forever begin
      @(negedge clk);
      if (dut_req_ready(p)) break;
      t++;
      if (t > 64) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout port %0d: no grant after %0d cycles, expected a grant", p, t);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  function automatic logic [12:0] rand_ctrl();
    int k;
    k = $urandom_range(0, 15);
    if (k == 13) return 13'd0;
    if (k > 13) return 13'($urandom_range(0, 8191));
    return 13'd1 << k;
  endfunction

  logic rand_done;
  int   g0, base;

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0; req_ctrl[p] = '0; req_src1[p] = '0; req_src2[p] = '0;
      resp_ready[p] = 1'b1; n_resp[p] = 0; grant_cyc[p] = 0; resp_cyc[p] = 0; last_res[p] = '0;
    end
    m_grants = 0;
    #1;
    chk("por_op_count", {16'd0, op_count}, 32'd0);
    chk("por_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single add: result 12, two cycles from grant to response.
    send(0, 13'h0800, 32'd5, 32'd7);
    repeat (3) @(negedge clk);
    chk("single_n_resp", n_resp[0], 32'd1);
    chk("single_result", last_res[0], 32'd12);
    chk("single_latency", resp_cyc[0] - grant_cyc[0], 32'd2);
    chk("single_op_count", {16'd0, op_count}, 32'd1);

    // Contention from a fresh reset: port 0 first, port 1 on the next cycle.
    do_reset();
    fork
      send(0, 13'h0400, 32'd10, 32'd3);
      send(1, 13'h0200, 32'hFFFF_FFFF, 32'd1);
    join
    repeat (3) @(negedge clk);
    chk("cont_sub_result", last_res[0], 32'd7);
    chk("cont_slt_result", last_res[1], 32'd1);
    chk("cont_order", grant_cyc[1] - grant_cyc[0], 32'd1);
    fork
      begin send(0, 13'h0010, 32'hF0, 32'h0F); send(0, 13'h0020, 32'h1, 32'h2); end
      begin send(1, 13'h0080, 32'hFF, 32'h3C); send(1, 13'h1000, 32'h0, 32'h0); end
    join
    repeat (3) @(negedge clk);
    chk("cont_alt_or", last_res[0], 32'h3);
    chk("cont_alt_nand", last_res[1], 32'hFFFF_FFFF);

    // Back-pressure on port 0 while port 1 keeps issuing sll.
    @(posedge clk); #1 resp_ready[0] = 1'b0;
    send(0, 13'h0800, 32'd1, 32'd1);
    base = n_resp[1];
    @(negedge clk);
    chk("bp_req0_blocked", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    send(1, 13'h0008, 32'd4, 32'd1);
    g0 = grant_cyc[1];
    for (int i = 0; i < 3; i++) begin
      send(1, 13'h0008, 32'd4, 32'd1);
      chk("bp_p1_spacing", grant_cyc[1] - g0, 32'd2);
      g0 = grant_cyc[1];
    end
    repeat (3) @(negedge clk);
    chk("bp_p1_count", n_resp[1] - base, 32'd4);
    chk("bp_p1_result", last_res[1], 32'd16);
    chk("bp_resp0_held", resp0_result, 32'd2);
    chk("bp_req0_still_blocked", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1 resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, req0_ready}, 32'd1);
    repeat (2) @(negedge clk);

    // Reset while port 1 holds a result and an op is in the ALU.
    @(posedge clk); #1 resp_ready[1] = 1'b0;
    send(1, 13'h0800, 32'd1, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    send(0, 13'h0800, 32'd3, 32'd4);
    chk("mid_pre_resp1_valid", {31'd0, resp1_valid}, 32'd1);
    chk("mid_pre_alu_ctrl", {19'd0, alu_control}, 32'h0800);
    rst = 1'b1;
    #1;
    chk("mid_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("mid_op_count", {16'd0, op_count}, 32'd0);
    chk("mid_alu_ctrl", {19'd0, alu_control}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; resp_ready[1] = 1'b1;
    fork
      send(1, 13'h0001, 32'd0, 32'h0000_ABCD);
      send(0, 13'h0004, 32'd4, 32'h0000_0100);
    join
    repeat (3) @(negedge clk);
    chk("mid_first_grant_p0", grant_cyc[1] - grant_cyc[0], 32'd1);
    chk("mid_srl_result", last_res[0], 32'h10);
    chk("mid_lui_result", last_res[1], 32'hABCD_0000);

    // Random traffic with random response back-pressure.
    rand_done = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        fork
          for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 send(0, rand_ctrl(), $urandom, $urandom);
          end
          for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 send(1, rand_ctrl(), $urandom, $urandom);
          end
        join
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        resp_ready[0] = ($urandom_range(0, 3) != 0);
        resp_ready[1] = ($urandom_range(0, 3) != 0);
      end
    join
    resp_ready[0] = 1'b1; resp_ready[1] = 1'b1;
    repeat (4) @(negedge clk);

    // Counter wrap: 65536 lui ops alternating between the ports.
    do_reset();
    base = m_grants;
    fork
      for (int i = 0; i < 32768; i++) send(0, 13'h0001, 32'd0, 32'h0000_1234);
      for (int i = 0; i < 32768; i++) send(1, 13'h0001, 32'd0, 32'h0000_1234);
    join
    repeat (3) @(negedge clk);
    chk("wrap_grants", m_grants - base, 32'd65536);
    chk("wrap_op_count", {16'd0, op_count}, 32'd0);
    chk("wrap_lui_p0", last_res[0], 32'h1234_0000);
    chk("wrap_lui_p1", last_res[1], 32'h1234_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
